// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, R-type
// funct codes, ALU control words, pc_src / alu_src_b selects and the FSM
// state encoding (also exported on the debug state port).
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;
    localparam logic [5:0] FN_SLL = 6'h00;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;

    localparam logic [1:0] PC_SEQ    = 2'd0;  // ALU result (PC+4)
    localparam logic [1:0] PC_BRANCH = 2'd1;  // ALUOut (branch target)
    localparam logic [1:0] PC_JUMP   = 2'd2;  // jump target

    localparam logic [1:0] ASB_RT     = 2'd0;
    localparam logic [1:0] ASB_FOUR   = 2'd1;
    localparam logic [1:0] ASB_IMM    = 2'd2;
    localparam logic [1:0] ASB_IMM_SH = 2'd3;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11,
        S_TRAP      = 4'd12
    } state_e;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational R-type funct decoder.
//   funct    : IR[5:0]
//   alu_ctrl : ALU operation for the funct (ADD when unsupported)
//   valid    : funct is one of the supported R-type operations
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_ctrl,
    output logic       valid
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        valid    = 1'b1;
        case (funct)
            FN_ADD:  alu_ctrl = ALU_ADD;
            FN_SUB:  alu_ctrl = ALU_SUB;
            FN_AND:  alu_ctrl = ALU_AND;
            FN_OR:   alu_ctrl = ALU_OR;
            FN_SLT:  alu_ctrl = ALU_SLT;
            FN_SLL:  alu_ctrl = ALU_SLL;
            default: valid    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM for the toy MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback over a shared
// single-port memory with a ready handshake.
//   clk, Reset (async, active low)
//   opcode, funct, zero, mem_ready    : datapath / memory status
//   pc_write .. alu_ctrl              : datapath control selects and enables
//   state                             : current FSM state (debug)
//   illegal                           : sticky trap flag (held until reset)
//   instr_retired                     : completed-instruction count, wraps
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_retired
);

    localparam int WC_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q;
    logic [3:0]        dec_ctrl;
    logic              dec_valid;
    logic              mem_state, stalled, timeout;

    mips_alu_decoder u_alu_dec (
        .funct    (funct),
        .alu_ctrl (dec_ctrl),
        .valid    (dec_valid)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign stalled   = mem_state && !mem_ready;
    // The cycle that would be the WAIT_LIMIT-th stalled cycle aborts to TRAP.
    assign timeout   = (WAIT_LIMIT != 0) && stalled && (wait_q == WAIT_LAST);
    assign wait_d    = (stalled && !timeout && WAIT_LIMIT != 0) ? wait_q + WC_W'(1) : '0;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        pc_src     = PC_SEQ;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ASB_RT;
        alu_ctrl   = ALU_AND;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ASB_FOUR;
                alu_ctrl  = ALU_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout) begin
                    state_d = S_TRAP;
                end
            end
            S_DECODE: begin
                // Branch target precomputed while the opcode is decoded.
                alu_src_b = ASB_IMM_SH;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = dec_valid ? S_EXEC_R : S_TRAP;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)    state_d = S_MEM_WB;
                else if (timeout) state_d = S_TRAP;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = !timeout;
                if (mem_ready)    state_d = S_FETCH;
                else if (timeout) state_d = S_TRAP;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = dec_ctrl;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                alu_ctrl  = ALU_ADD;
                state_d   = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_src    = PC_BRANCH;
                pc_write  = zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = PC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
        // Reset must kill any in-flight memory request in the same cycle.
        if (!Reset) begin
            pc_write   = 1'b0;
            pc_src     = PC_SEQ;
            ir_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = ASB_RT;
            alu_ctrl   = ALU_AND;
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q != S_FETCH && state_q != S_TRAP && state_d == S_FETCH)
                retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign state         = state_q;
    assign illegal       = (state_q == S_TRAP);
    assign instr_retired = retired_q;

endmodule
